// File: rtl/moore_seq_det_param.sv
// Parametrised Moore sequence detector with KMP partial-match fallback and run-time overlap select.
// Optional saturating detection counter is built only when SEQ_DET_CNT_EN is defined.
module moore_seq_det_param #(
    parameter int                PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
    parameter int                CNT_W   = 8,
    localparam int               SW      = $clog2(PAT_LEN + 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In,
    input  logic             Mode,
    input  logic             Clr,
    output logic             OP,
    output logic [CNT_W-1:0] Match_Cnt,
    output logic [SW-1:0]    CS,
    output logic [SW-1:0]    NS
);

    localparam logic [SW-1:0] DET       = SW'(PAT_LEN);
    localparam logic [16:0]   PAT_EXT   = 17'(PATTERN);
    localparam logic          FIRST_BIT = PATTERN[PAT_LEN-1];
    localparam int            TBL_SIZE  = 2 ** (SW + 1);

    logic [SW-1:0] state_reg;
    logic [SW-1:0] state_next;
    logic [SW-1:0] trans_tbl [0:TBL_SIZE-1];

    // Longest suffix of (first k pattern bits, b) that is also a pattern prefix.
    // Bit i of the probe string is the i-th bit received; pattern bit j is PATTERN[PAT_LEN-1-j].
    function automatic int kmp_next(input int k, input int b);
        logic [16:0] s;
        int          res;
        logic        ok;
        s = '0;
        for (int i = 0; i < 17; i++) begin
            if (i < k) begin
                s = s | (((PAT_EXT >> (PAT_LEN - 1 - i)) & 17'd1) << i);
            end
        end
        if (b != 0) begin
            s = s | (17'd1 << k);
        end
        res = 0;
        for (int len = 1; len <= PAT_LEN; len++) begin
            if (len <= k + 1) begin
                ok = 1'b1;
                for (int j = 0; j < PAT_LEN; j++) begin
                    if (j < len) begin
                        if (((s >> (k + 1 - len + j)) & 17'd1) !=
                            ((PAT_EXT >> (PAT_LEN - 1 - j)) & 17'd1)) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    res = len;
                end
            end
        end
        return res;
    endfunction

    // Transition table indexed by {state, In}; unreachable codes map to S0.
    genvar gi, gb;
    generate
        for (gi = 0; gi < 2 ** SW; gi++) begin : g_state
            for (gb = 0; gb < 2; gb++) begin : g_bit
                if (gi <= PAT_LEN) begin : g_live
                    localparam int NXT = kmp_next(gi, gb);
                    assign trans_tbl[gi*2+gb] = SW'(NXT);
                end else begin : g_dead
                    assign trans_tbl[gi*2+gb] = '0;
                end
            end
        end
    endgenerate

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_reg <= '0;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = '0;
        if (state_reg > DET) begin
            state_next = '0;
        end else if (state_reg == DET && !Mode) begin
            state_next = (In == FIRST_BIT) ? SW'(1) : '0;
        end else begin
            state_next = trans_tbl[{state_reg, In}];
        end
    end

    always_comb begin
        OP = (state_reg == DET);
    end

    assign CS = state_reg;
    assign NS = state_next;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_reg;

    // Clear has priority; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_reg <= '0;
        end else if (Clr) begin
            cnt_reg <= '0;
        end else if (state_next == DET && cnt_reg != {CNT_W{1'b1}}) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign Match_Cnt = cnt_reg;
`else
    logic unused_clr;

    assign unused_clr = Clr;
    assign Match_Cnt  = '0;
`endif

endmodule

// File: tb/tb_moore_seq_det_param.sv
// Directed bench for moore_seq_det_param: three instances (1010, 1101, 1010 with 2-bit counter)
// share one stimulus; a vector table plus hand-written reset/NS corner cases.
module tb_moore_seq_det_param;

`ifdef SEQ_DET_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_bit;
    logic       mode;
    logic       clr;

    logic       op_a, op_b, op_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic [2:0] cs_a, cs_b, cs_c;
    logic [2:0] ns_a, ns_b, ns_c;

    int total = 0;
    int bad   = 0;

    moore_seq_det_param dut_a (
        .Clk(clk), .Rst(rst), .In(in_bit), .Mode(mode), .Clr(clr),
        .OP(op_a), .Match_Cnt(cnt_a), .CS(cs_a), .NS(ns_a)
    );

    moore_seq_det_param #(.PAT_LEN(4), .PATTERN(4'b1101), .CNT_W(8)) dut_b (
        .Clk(clk), .Rst(rst), .In(in_bit), .Mode(mode), .Clr(clr),
        .OP(op_b), .Match_Cnt(cnt_b), .CS(cs_b), .NS(ns_b)
    );

    moore_seq_det_param #(.PAT_LEN(4), .PATTERN(4'b1010), .CNT_W(2)) dut_c (
        .Clk(clk), .Rst(rst), .In(in_bit), .Mode(mode), .Clr(clr),
        .OP(op_c), .Match_Cnt(cnt_c), .CS(cs_c), .NS(ns_c)
    );

    // Clock starts high so the 15 ns reset release lands on a falling edge.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic rst_first;
        logic in_b;
        logic mode;
        logic clr;
        int   sel;
        int   cs;
        logic op;
        int   cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic b, input logic m, input logic c,
                       input int sel, input int cs, input logic op, input int cnt);
        vec_t v;
        v.rst_first = r; v.in_b = b; v.mode = m; v.clr = c;
        v.sel = sel; v.cs = cs; v.op = op; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic b, input logic m, input logic c);
        in_bit = b;
        mode   = m;
        clr    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; in_bit = 1'b0; mode = 1'b0; clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic int exp_cnt(input int c);
        return CNT_ON ? c : 0;
    endfunction

    initial begin
        // Test 1: 1010 stream, non-overlap
        add(0,1,0,0, 0,1,0,0); add(0,0,0,0, 0,2,0,0); add(0,1,0,0, 0,3,0,0);
        add(0,0,0,0, 0,4,1,1); add(0,1,0,0, 0,1,0,1); add(0,0,0,0, 0,2,0,1);
        // Test 2: same stream, overlap; then a mid-stream Mode change
        add(1,1,1,0, 0,1,0,0); add(0,0,1,0, 0,2,0,0); add(0,1,1,0, 0,3,0,0);
        add(0,0,1,0, 0,4,1,1); add(0,1,1,0, 0,3,0,1); add(0,0,1,0, 0,4,1,2);
        add(0,0,0,0, 0,0,0,2); add(0,1,0,0, 0,1,0,2); add(0,0,0,0, 0,2,0,2);
        add(0,1,0,0, 0,3,0,2); add(0,0,0,0, 0,4,1,3); add(0,0,1,0, 0,0,0,3);
        // Test 3: pattern 1101, KMP holds S2 on repeated ones
        add(1,1,0,0, 1,1,0,0); add(0,1,0,0, 1,2,0,0); add(0,1,0,0, 1,2,0,0);
        add(0,0,0,0, 1,3,0,0); add(0,1,0,0, 1,4,1,1);
        // Test 5: 2-bit counter saturates, overlap, 1010101010 then 1010
        add(1,1,1,0, 2,1,0,0); add(0,0,1,0, 2,2,0,0); add(0,1,1,0, 2,3,0,0);
        add(0,0,1,0, 2,4,1,1); add(0,1,1,0, 2,3,0,1); add(0,0,1,0, 2,4,1,2);
        add(0,1,1,0, 2,3,0,2); add(0,0,1,0, 2,4,1,3); add(0,1,1,0, 2,3,0,3);
        add(0,0,1,0, 2,4,1,3); add(0,1,1,0, 2,3,0,3); add(0,0,1,0, 2,4,1,3);
        add(0,1,1,0, 2,3,0,3); add(0,0,1,0, 2,4,1,3);
        // Test 6: Clr on a detecting edge wins over the increment
        add(1,1,1,0, 0,1,0,0); add(0,0,1,0, 0,2,0,0); add(0,1,1,0, 0,3,0,0);
        add(0,0,1,0, 0,4,1,1); add(0,1,1,0, 0,3,0,1); add(0,0,1,0, 0,4,1,2);
        add(0,1,1,0, 0,3,0,2); add(0,0,1,1, 0,4,1,0); add(0,1,1,0, 0,3,0,0);
        add(0,0,1,0, 0,4,1,1); add(0,1,1,1, 0,3,0,0);

        rst = 1'b0; in_bit = 1'b0; mode = 1'b0; clr = 1'b0;
        #14;
        check("reset_cs_a", 32'(cs_a), 0);
        check("reset_op_a", 32'(op_a), 0);
        check("reset_cnt_a", 32'(cnt_a), 0);
        check("reset_cs_b", 32'(cs_b), 0);
        check("reset_cnt_c", 32'(cnt_c), 0);
        #1;
        rst = 1'b1;

        foreach (vecs[i]) begin
            logic [31:0] got_cs, got_op, got_cnt;
            if (vecs[i].rst_first) do_reset();
            step(vecs[i].in_b, vecs[i].mode, vecs[i].clr);
            case (vecs[i].sel)
                0:       begin got_cs = 32'(cs_a); got_op = 32'(op_a); got_cnt = 32'(cnt_a); end
                1:       begin got_cs = 32'(cs_b); got_op = 32'(op_b); got_cnt = 32'(cnt_b); end
                default: begin got_cs = 32'(cs_c); got_op = 32'(op_c); got_cnt = 32'(cnt_c); end
            endcase
            check($sformatf("vec%0d_cs", i), got_cs, 32'(vecs[i].cs));
            check($sformatf("vec%0d_op", i), got_op, 32'(vecs[i].op));
            check($sformatf("vec%0d_cnt", i), got_cnt, 32'(exp_cnt(vecs[i].cnt)));
        end

        // Test 4: asynchronous reset mid-cycle drops the partial match
        do_reset();
        step(1, 0, 0); step(0, 0, 0); step(1, 0, 0);
        check("pre_async_cs", 32'(cs_a), 3);
        #3;
        rst = 1'b0;
        #1;
        check("async_cs", 32'(cs_a), 0);
        check("async_op", 32'(op_a), 0);
        #1;
        rst = 1'b1;
        step(0, 0, 0);
        check("post_rst_cs0", 32'(cs_a), 0);
        step(1, 0, 0);
        check("post_rst_cs1", 32'(cs_a), 1);
        step(0, 0, 0);
        check("post_rst_cs2", 32'(cs_a), 2);
        check("post_rst_op", 32'(op_a), 0);

        // Combinational next state from S2 and from DET under both modes
        in_bit = 1'b1; #1;
        check("ns_s2_in1", 32'(ns_a), 3);
        in_bit = 1'b0; #1;
        check("ns_s2_in0", 32'(ns_a), 0);
        step(1, 0, 0); step(0, 0, 0);
        check("det_op", 32'(op_a), 1);
        mode = 1'b1; in_bit = 1'b1; #1;
        check("ns_det_ovl_in1", 32'(ns_a), 3);
        mode = 1'b0; #1;
        check("ns_det_non_in1", 32'(ns_a), 1);
        in_bit = 1'b0; #1;
        check("ns_det_non_in0", 32'(ns_a), 0);
        check("ns_b_s0_in0", 32'(ns_b), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
